ldl_ram_ctrl: RTL and testbench



---
 rtl/ldl_ram_ctrl_pkg.sv | 22 ++
 rtl/ldl_fifo2.sv | 57 +++++
 rtl/ldl_ram_ctrl.sv | 155 +++++++++++++++
 tb/tb_ldl_ram_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldl_ram_ctrl_pkg.sv
// ldl_ram_ctrl_pkg: shared types and sizing constants for the RAM port controller.
// Contents: controller state enum, response buffer depth, buffer-count and credit widths.
// Imported by ldl_fifo2 and ldl_ram_ctrl.
package ldl_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Response buffer depth; also the maximum number of reads that may be
  // buffered plus in flight at any time.
  localparam int RSP_DEPTH = 2;

  // Width of the buffer occupancy count (0..RSP_DEPTH).
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  // Width of the credit sum fifo_cnt + inflight (0..RSP_DEPTH+1).
  localparam int CRED_W = $clog2(RSP_DEPTH + 2);

endpackage

// File: rtl/ldl_fifo2.sv
// ldl_fifo2: 2-entry registered FIFO holding read responses.
// Latency: a push is visible at the head on the next cycle; head is read straight from registers.
// Backpressure: none internally; the caller's credit check guarantees no overflow or underflow.
// Ports: clk, rstn (async active-low), push/push_data (write side), pop (read side),
//        head (oldest entry), cnt (occupancy 0..2).
module ldl_fifo2
  import ldl_ram_ctrl_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head,
  output logic [CNT_W-1:0]  cnt
);

  logic [DWIDTH-1:0] mem [RSP_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = mem[rd_ptr];

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (cnt == CNT_W'(RSP_DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(pop && (cnt == '0)));
`endif

endmodule

// File: rtl/ldl_ram_ctrl.sv
// ldl_ram_ctrl: valid/ready port controller in front of one port of a 1-cycle synchronous-read RAM.
// Latency: read accepted in cycle N shows rsp_valid in N+2 (buffer empty); one command per cycle sustained.
// Backpressure: cmd_ready drops once buffered + in-flight reads reach 2; rsp backpressure never drops data.
// Ports: clk, rstn (async active-low); cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata (command);
//        rsp_valid/rsp_ready/rsp_rdata (response); init_req/busy (init sweep control/status);
//        ram_re/ram_we/ram_addr/ram_din/ram_dout (RAM port).
// Optional feature: define LDL_RAM_CTRL_INIT_EN to build the INIT/DRAIN fill sweep.
module ldl_ram_ctrl
  import ldl_ram_ctrl_pkg::*;
#(
  parameter int                DWIDTH   = 8,
  parameter int                AWIDTH   = 4,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  input  logic              init_req,
  output logic              busy,
  output logic              ram_re,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  input  logic [DWIDTH-1:0] ram_dout
);

  // live is low in reset and for the edge that releases it, so every RAM
  // enable and cmd_ready sits at 0 while rstn is asserted.
  logic              live;
  logic              inflight;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              rsp_pop;
  logic [CRED_W-1:0] credit_used;
  logic              credit_ok;
  logic              run_st;
  logic              sweep_on;
  logic [AWIDTH-1:0] sweep;
  logic              fire_wr;
  logic              fire_rd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live     <= 1'b0;
      inflight <= 1'b0;
    end else begin
      live     <= 1'b1;
      inflight <= fire_rd;
    end
  end

`ifdef LDL_RAM_CTRL_INIT_EN
  localparam int DEPTH = 1 << AWIDTH;

  state_t state;
  logic   busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= INIT;
      sweep  <= '0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (live) begin
            // The counter wraps to 0 on the last address, ready for the next sweep.
            sweep <= sweep + AWIDTH'(1);
            if (sweep == AWIDTH'(DEPTH - 1)) begin
              state  <= RUN;
              busy_q <= 1'b0;
            end
          end
        end
        RUN: begin
          if (init_req) begin
            state  <= DRAIN;
            busy_q <= 1'b1;
          end
        end
        DRAIN: begin
          // Wait for the last issued read to land in the buffer before the
          // sweep starts overwriting the RAM.
          if (!inflight) begin
            state <= INIT;
          end
        end
        default: begin
          state  <= RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign run_st   = (state == RUN);
  assign sweep_on = live & (state == INIT);
  assign busy     = busy_q;
`else
  logic unused_ok;
  assign unused_ok = ^{init_req, INIT_VAL};
  assign run_st    = 1'b1;
  assign sweep_on  = 1'b0;
  assign sweep     = '0;
  assign busy      = 1'b0;
`endif

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_pop   = rsp_valid & rsp_ready;

  // A slot is reserved for every buffered and in-flight read; a pop this
  // cycle frees one, so accepting at the limit while popping is allowed.
  assign credit_used = CRED_W'(fifo_cnt) + CRED_W'(inflight) - CRED_W'(rsp_pop);
  assign credit_ok   = (credit_used < CRED_W'(RSP_DEPTH));

  assign cmd_ready = live & run_st & credit_ok;
  assign fire_wr   = cmd_valid & cmd_ready & cmd_we;
  assign fire_rd   = cmd_valid & cmd_ready & ~cmd_we;

  always_comb begin
    ram_re   = fire_rd;
    ram_we   = fire_wr | sweep_on;
    ram_addr = '0;
    ram_din  = '0;
    if (sweep_on) begin
      ram_addr = sweep;
      ram_din  = INIT_VAL;
    end else if (fire_wr | fire_rd) begin
      ram_addr = cmd_addr;
      if (fire_wr) begin
        ram_din = cmd_wdata;
      end
    end
  end

  // RAM data is valid the cycle after issue, which is exactly when inflight is set.
  ldl_fifo2 #(
    .DWIDTH (DWIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight),
    .push_data (ram_dout),
    .pop       (rsp_pop),
    .head      (rsp_rdata),
    .cnt       (fifo_cnt)
  );

endmodule

// File: tb/tb_ldl_ram_ctrl.sv
// tb_ldl_ram_ctrl: directed bench for ldl_ram_ctrl with a behavioural 1-cycle RAM on its port.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Works with or without LDL_RAM_CTRL_INIT_EN defined.
module tb_ldl_ram_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       init_req, busy;
  logic       ram_re, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  ldl_ram_ctrl #(
    .DWIDTH   (8),
    .AWIDTH   (4),
    .INIT_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_req  (init_req),
    .busy      (busy),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // One port of the external synchronous-read RAM.
  logic [7:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= ram_mem[ram_addr];
  end

`ifdef LDL_RAM_CTRL_INIT_EN
  localparam logic BUSY_RST = 1'b1;
  localparam logic [7:0] A15_LATE = 8'h00;
`else
  localparam logic BUSY_RST = 1'b0;
  localparam logic [7:0] A15_LATE = 8'hF0;
`endif
  // {rsp_valid, rsp_rdata, cmd_ready, ram_re, ram_we, ram_addr, ram_din, busy}
  localparam logic [24:0] RST_OUTS = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, BUSY_RST};

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [27];
  logic [7:0] stream_exp [16];
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         st;
  int         tot;

  function automatic logic [24:0] outs();
    return {rsp_valid, rsp_rdata, cmd_ready, ram_re, ram_we, ram_addr, ram_din, busy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at the falling edge: a response that will pop at the next edge is compared.
  task automatic sample();
    logic [7:0] e;
    if (rsp_valid === 1'b1 && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got %0h, expected no response", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", {56'd0, rsp_rdata}, {56'd0, e});
      end
    end
  endtask

  task automatic adv();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] e, output int stalls);
    bit done;
    done      = 1'b0;
    stalls    = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        if (!we) exp_q.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
      end
      adv();
    end
    cmd_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: addr %0h never accepted, required accept within 64 cycles", a);
    end
  endtask

  task automatic drain(input string tag);
    bit done;
    done      = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rsp_valid !== 1'b1) begin
        done = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        adv();
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", tag, exp_q.size());
    end
  endtask

`ifdef LDL_RAM_CTRL_INIT_EN
  task automatic sweep_chk(input string tag, input int rsp_on_at);
    for (int i = 0; i < 16; i++) begin
      if (i == rsp_on_at) rsp_ready = 1'b1;
      @(negedge clk);
      chk(tag, {ram_we, ram_re, ram_addr, ram_din, busy, cmd_ready},
               {1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0});
      adv();
    end
    @(negedge clk);
    chk("first_run_cycle", {busy, cmd_ready, ram_we}, 3'b010);
    adv();
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) vecs[i] = '{1'b0, 4'(i), 8'h00, 8'h00};
    vecs[16] = '{1'b1, 4'd1,  8'h11, 8'h00};
    vecs[17] = '{1'b1, 4'd2,  8'h22, 8'h00};
    vecs[18] = '{1'b1, 4'd4,  8'h44, 8'h00};
    vecs[19] = '{1'b0, 4'd1,  8'h00, 8'h11};
    vecs[20] = '{1'b0, 4'd2,  8'h00, 8'h22};
    vecs[21] = '{1'b1, 4'd2,  8'h5A, 8'h00};
    vecs[22] = '{1'b0, 4'd2,  8'h00, 8'h5A};
    vecs[23] = '{1'b0, 4'd4,  8'h00, 8'h44};
    vecs[24] = '{1'b1, 4'd15, 8'hF0, 8'h00};
    vecs[25] = '{1'b0, 4'd15, 8'h00, 8'hF0};
    vecs[26] = '{1'b0, 4'd0,  8'h00, 8'h00};
    stream_exp = '{8'h00, 8'h11, 8'h5A, 8'hA5, 8'h44, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};

    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; init_req = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", {39'd0, outs()}, {39'd0, RST_OUTS});
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

`ifdef LDL_RAM_CTRL_INIT_EN
    sweep_chk("sweep", 99);
`else
    @(negedge clk);
    chk("ready_after_rst", {cmd_ready, busy}, 2'b10);
    adv();
    for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 8'h00, 8'h00, st);
`endif

    // Table-driven commands with the consumer always ready
    rsp_ready = 1'b1;
    for (int i = 0; i < 27; i++) issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, st);
    drain("table");

    // Write then read of the same address on the next cycle
    issue(1'b1, 4'd3, 8'hA5, 8'h00, st);
    issue(1'b0, 4'd3, 8'h00, 8'hA5, st);
    @(negedge clk);
    chk("lat_n2_valid", rsp_valid, 1'b0);
    adv();
    @(negedge clk);
    chk("lat_n3_data", {rsp_valid, rsp_rdata}, {1'b1, 8'hA5});
    adv();
    drain("latency");

    // Response backpressure: two reads buffered, third held until a pop
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'd1;
    @(negedge clk);
    chk("bp_acc1", cmd_ready, 1'b1);
    exp_q.push_back(8'h11);
    adv();
    cmd_addr = 4'd2;
    @(negedge clk);
    chk("bp_acc2", cmd_ready, 1'b1);
    exp_q.push_back(8'h5A);
    adv();
    cmd_addr = 4'd3;
    @(negedge clk);
    chk("bp_full", cmd_ready, 1'b0);
    adv();
    @(negedge clk);
    chk("bp_hold", {cmd_ready, rsp_valid, rsp_rdata}, {1'b0, 1'b1, 8'h11});
    adv();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_and_accept", cmd_ready, 1'b1);
    exp_q.push_back(8'hA5);
    adv();
    cmd_valid = 1'b0;
    drain("backpressure");

    // Streaming reads: one accept per cycle
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 4'(i), 8'h00, stream_exp[i], st);
      tot += st;
    end
    chk("stream_stalls", tot, 0);
    drain("stream");

    // init_req with two responses buffered
    rsp_ready = 1'b0;
    issue(1'b0, 4'd1, 8'h00, 8'h11, st);
    issue(1'b0, 4'd2, 8'h00, 8'h5A, st);
    init_req = 1'b1;
`ifdef LDL_RAM_CTRL_INIT_EN
    @(negedge clk);
    chk("init_req_cycle_busy", busy, 1'b0);
    adv();
    init_req = 1'b0;
    @(negedge clk);
    chk("drain_state", {busy, cmd_ready, ram_we, rsp_valid}, 4'b1001);
    adv();
    sweep_chk("sweep_reinit", 3);
    chk("old_rsp_popped", exp_q.size(), 0);
    issue(1'b0, 4'd2, 8'h00, 8'h00, st);
    issue(1'b0, 4'd1, 8'h00, 8'h00, st);
    drain("reinit");
`else
    @(negedge clk);
    adv();
    init_req = 1'b0;
    @(negedge clk);
    chk("init_ignored", {busy, ram_we}, 2'b00);
    adv();
    drain("init_ignored");
    issue(1'b0, 4'd2, 8'h00, 8'h5A, st);
    drain("no_reinit");
`endif

    // Reset asserted with a response buffered
    rsp_ready = 1'b0;
    issue(1'b0, 4'd15, 8'h00, A15_LATE, st);
`ifdef LDL_RAM_CTRL_INIT_EN
    init_req = 1'b1;
    @(negedge clk);
    adv();
    init_req = 1'b0;
    @(negedge clk);
    adv();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("sweep_pre_rst", {ram_we, ram_addr, rsp_valid}, {1'b1, 4'(i), 1'b1});
      adv();
    end
    #1;
    chk("at_addr7", ram_addr, 4'd7);
    rstn = 1'b0;
    #1;
    chk("rst_mid_sweep", {39'd0, outs()}, {39'd0, RST_OUTS});
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    sweep_chk("sweep_restart", 99);
    issue(1'b0, 4'd5, 8'h00, 8'h00, st);
    drain("after_restart");
`else
    @(negedge clk);
    adv();
    #1;
    chk("buffered_before_rst", rsp_valid, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_stream", {39'd0, outs()}, {39'd0, RST_OUTS});
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_rst2", {cmd_ready, rsp_valid, busy}, 3'b100);
    adv();
    issue(1'b0, 4'd15, 8'h00, 8'hF0, st);
    drain("after_rst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
